// File: rtl/bbox_draw.sv
// Draws a 1-pixel rectangle outline into column-major RGB pixel memory,
// one 16-bit word per channel, edges in order TOP, BOTTOM, LEFT, RIGHT.
module bbox_draw #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  input  logic [10:0] x_min,
  input  logic [10:0] x_max,
  input  logic [10:0] y_min,
  input  logic [10:0] y_max,
  input  logic [15:0] colour_r,
  input  logic [15:0] colour_g,
  input  logic [15:0] colour_b,
  output logic [23:0] addr,
  output logic [15:0] wrdata,
  output logic        wren,
  input  logic        waitrequest
);

  typedef enum logic [2:0] {IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE} state_t;

  localparam logic [10:0] X_LIM = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LIM = 11'(HEIGHT - 1);

  state_t      state, state_nx;
  logic [10:0] x, y, x_nx, y_nx;
  logic [1:0]  c, c_nx;
  logic [10:0] x0, x1, y0, y1, x0_nx, x1_nx, y0_nx, y1_nx;
  logic [15:0] col_r, col_g, col_b, col_r_nx, col_g_nx, col_b_nx;
  logic [10:0] x_min_c, x_max_c, y_min_c, y_max_c;
  logic        accept, has_mid;
  state_t      vert_state;
  logic [23:0] addr_nx;
  logic [15:0] wrdata_nx;
  logic        wren_nx;

  assign x_min_c = (x_min > X_LIM) ? X_LIM : x_min;
  assign x_max_c = (x_max > X_LIM) ? X_LIM : x_max;
  assign y_min_c = (y_min > Y_LIM) ? Y_LIM : y_min;
  assign y_max_c = (y_max > Y_LIM) ? Y_LIM : y_max;

  assign accept = wren && !waitrequest;
  // LEFT/RIGHT cover only the rows strictly between the top and bottom edges
  assign has_mid    = ({1'b0, y1} >= ({1'b0, y0} + 12'd2));
  assign vert_state = has_mid ? LEFT : DONE;

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    c_nx     = c;
    x0_nx    = x0;
    x1_nx    = x1;
    y0_nx    = y0;
    y1_nx    = y1;
    col_r_nx = col_r;
    col_g_nx = col_g;
    col_b_nx = col_b;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          x0_nx    = x_min_c;
          x1_nx    = x_max_c;
          y0_nx    = y_min_c;
          y1_nx    = y_max_c;
          col_r_nx = colour_r;
          col_g_nx = colour_g;
          col_b_nx = colour_b;
          x_nx     = x_min_c;
          y_nx     = y_min_c;
          c_nx     = 2'd0;
          if (x_min_c > x_max_c || y_min_c > y_max_c) state_nx = DONE;
          else state_nx = TOP;
        end
      end
      default: begin
        if (accept) begin
          if (c != 2'd2) begin
            c_nx = c + 2'd1;
          end else begin
            c_nx = 2'd0;
            case (state)
              TOP: begin
                if (x != x1) begin
                  x_nx = x + 11'd1;
                end else if (y1 != y0) begin
                  state_nx = BOTTOM;
                  x_nx     = x0;
                  y_nx     = y1;
                end else begin
                  state_nx = vert_state;
                  x_nx     = x0;
                  y_nx     = y0 + 11'd1;
                end
              end
              BOTTOM: begin
                if (x != x1) begin
                  x_nx = x + 11'd1;
                end else begin
                  state_nx = vert_state;
                  x_nx     = x0;
                  y_nx     = y0 + 11'd1;
                end
              end
              LEFT: begin
                if (y != y1 - 11'd1) begin
                  y_nx = y + 11'd1;
                end else if (x1 != x0) begin
                  state_nx = RIGHT;
                  x_nx     = x1;
                  y_nx     = y0 + 11'd1;
                end else begin
                  state_nx = DONE;
                end
              end
              default: begin
                if (y != y1 - 11'd1) y_nx = y + 11'd1;
                else state_nx = DONE;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    addr_nx = 24'(x_nx) * 24'(HEIGHT * 3) + 24'(y_nx) * 24'd3 + 24'(c_nx);
    case (c_nx)
      2'd0:    wrdata_nx = col_r_nx;
      2'd1:    wrdata_nx = col_g_nx;
      default: wrdata_nx = col_b_nx;
    endcase
    wren_nx = (state_nx == TOP) || (state_nx == BOTTOM) ||
              (state_nx == LEFT) || (state_nx == RIGHT);
  end

  // Outputs are registered from the next-state values so they align with state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      c      <= '0;
      x0     <= '0;
      x1     <= '0;
      y0     <= '0;
      y1     <= '0;
      col_r  <= '0;
      col_g  <= '0;
      col_b  <= '0;
      wren   <= 1'b0;
      done   <= 1'b0;
      addr   <= '0;
      wrdata <= '0;
    end else begin
      state  <= state_nx;
      x      <= x_nx;
      y      <= y_nx;
      c      <= c_nx;
      x0     <= x0_nx;
      x1     <= x1_nx;
      y0     <= y0_nx;
      y1     <= y1_nx;
      col_r  <= col_r_nx;
      col_g  <= col_g_nx;
      col_b  <= col_b_nx;
      wren   <= wren_nx;
      done   <= (state_nx == DONE);
      addr   <= addr_nx;
      wrdata <= wrdata_nx;
    end
  end

endmodule

// File: tb/tb_bbox_draw.sv
// Randomised bench for bbox_draw: a pixel-list model predicts every write,
// plus literal checks on the documented corner cases.
module tb_bbox_draw;
  localparam int W = 100;
  localparam int H = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [10:0] x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic [15:0] colour_r = '0, colour_g = '0, colour_b = '0;
  logic [23:0] addr;
  logic [15:0] wrdata;
  logic        wren;
  logic        waitrequest = 1'b0;

  bbox_draw #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .colour_r(colour_r), .colour_g(colour_g), .colour_b(colour_b),
    .addr(addr), .wrdata(wrdata), .wren(wren), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_mode = 0;  // 0: no stall, 1: random stall, 2: driven by stimulus

  logic [39:0] exp_q[$];
  logic        busy = 1'b0;
  logic        done_exp = 1'b0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          acc_addr[$];
  int          acc_data[$];
  int          acc_cyc[$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endfunction

  function automatic void push_px(int px, int py, logic [15:0] r, logic [15:0] g, logic [15:0] b);
    logic [15:0] cols[3];
    cols[0] = r; cols[1] = g; cols[2] = b;
    for (int ch = 0; ch < 3; ch++)
      exp_q.push_back({24'(px * H * 3 + py * 3 + ch), cols[ch]});
  endfunction

  // Expected write list: outline pixels in edge order, each pixel once
  function automatic void build(int ax0, int ax1, int ay0, int ay1, logic [15:0] r, logic [15:0] g, logic [15:0] b);
    int bx0, bx1, by0, by1;
    bx0 = (ax0 > W - 1) ? W - 1 : ax0;
    bx1 = (ax1 > W - 1) ? W - 1 : ax1;
    by0 = (ay0 > H - 1) ? H - 1 : ay0;
    by1 = (ay1 > H - 1) ? H - 1 : ay1;
    exp_q.delete();
    if (bx0 > bx1 || by0 > by1) return;
    for (int px = bx0; px <= bx1; px++) push_px(px, by0, r, g, b);
    if (by1 != by0) for (int px = bx0; px <= bx1; px++) push_px(px, by1, r, g, b);
    for (int py = by0 + 1; py <= by1 - 1; py++) push_px(bx0, py, r, g, b);
    if (bx1 != bx0) for (int py = by0 + 1; py <= by1 - 1; py++) push_px(bx1, py, r, g, b);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (wr_mode == 1) waitrequest = ($urandom_range(0, 3) == 0);
    else if (wr_mode == 0) waitrequest = 1'b0;
  end

  // Compare process: check outputs, then advance the model to the next cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_wren", wren, 0);
      check("rst_done", done, 0);
      check("rst_addr", addr, 0);
      check("rst_wrdata", wrdata, 0);
      exp_q.delete();
      busy = 1'b0;
      done_exp = 1'b0;
    end else begin
      check("wren", wren, busy);
      check("done", done, done_exp);
      if (busy) begin
        check("addr", addr, exp_q[0][39:16]);
        check("wrdata", wrdata, exp_q[0][15:0]);
      end
      if (!busy) begin
        if (start) begin
          start_cyc = cyc;
          build(x_min, x_max, y_min, y_max, colour_r, colour_g, colour_b);
          if (exp_q.size() == 0) done_exp = 1'b1;
          else begin busy = 1'b1; done_exp = 1'b0; end
        end
      end else if (!waitrequest) begin
        acc_addr.push_back(int'(addr));
        acc_data.push_back(int'(wrdata));
        acc_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin busy = 1'b0; done_exp = 1'b1; end
      end
    end
  end

  task automatic set_box(int ax0, int ax1, int ay0, int ay1, logic [15:0] r, logic [15:0] g, logic [15:0] b);
    x_min = 11'(ax0); x_max = 11'(ax1); y_min = 11'(ay0); y_max = 11'(ay1);
    colour_r = r; colour_g = g; colour_b = b;
  endtask

  task automatic launch(int ax0, int ax1, int ay0, int ay1, logic [15:0] r, logic [15:0] g, logic [15:0] b);
    acc_addr.delete(); acc_data.delete(); acc_cyc.delete();
    @(posedge clk); #1;
    set_box(ax0, ax1, ay0, ay1, r, g, b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done) begin done_cyc = cyc; return; end
    end
    check("done_timeout", done, 1);
  endtask

  task automatic draw(int ax0, int ax1, int ay0, int ay1, logic [15:0] r, logic [15:0] g, logic [15:0] b);
    launch(ax0, ax1, ay0, ay1, r, g, b);
    wait_done(4000);
    $display("draw (%0d,%0d)-(%0d,%0d): %0d writes, done %0d cycles after start",
             ax0, ay0, ax1, ay1, acc_addr.size(), done_cyc - start_cyc);
  endtask

  initial begin
    int hits;
    int dups;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal box
    draw(10, 12, 20, 22, 16'h00FF, 16'h0000, 16'h0F0F);
    check("t1_count", acc_addr.size(), 24);
    check("t1_first_lat", acc_cyc[0] - start_cyc, 1);
    check("t1_last_cyc", acc_cyc[23] - start_cyc, 24);
    check("t1_done_cyc", done_cyc - start_cyc, 25);
    check("t1_addr0", acc_addr[0], 3060);
    check("t1_data0", acc_data[0], 32'h00FF);
    check("t1_addr1", acc_addr[1], 3061);
    check("t1_data1", acc_data[1], 0);
    check("t1_last_addr", acc_addr[23], 3665);
    hits = 0;
    foreach (acc_addr[i]) if (acc_addr[i] >= 3363 && acc_addr[i] <= 3365) hits++;
    check("t1_interior", hits, 0);

    // Empty box
    draw(99, 0, 99, 0, 16'h1111, 16'h2222, 16'h3333);
    check("empty_count", acc_addr.size(), 0);
    check("empty_done_cyc", done_cyc - start_cyc, 1);

    // Single pixel and single row
    draw(5, 5, 5, 5, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    check("px_count", acc_addr.size(), 3);
    check("px_a0", acc_addr[0], 1515);
    check("px_a1", acc_addr[1], 1516);
    check("px_a2", acc_addr[2], 1517);
    draw(0, 3, 7, 7, 16'h1234, 16'h5678, 16'h9ABC);
    check("row_count", acc_addr.size(), 12);
    dups = 0;
    foreach (acc_addr[i]) for (int j = i + 1; j < acc_addr.size(); j++) if (acc_addr[i] == acc_addr[j]) dups++;
    check("row_dups", dups, 0);

    // Four-cycle stall on the second write
    wr_mode = 2;
    launch(10, 12, 20, 22, 16'h00FF, 16'h0000, 16'h0F0F);
    @(posedge clk); #1 waitrequest = 1'b1;
    repeat (4) @(posedge clk);
    #1 waitrequest = 1'b0;
    wait_done(200);
    check("stall_count", acc_addr.size(), 24);
    check("stall_done_cyc", done_cyc - start_cyc, 29);
    wr_mode = 0;

    // Start pulses during TOP and LEFT are ignored
    launch(10, 12, 20, 22, 16'h00FF, 16'h0000, 16'h0F0F);
    repeat (2) @(posedge clk);
    #1 set_box(0, 50, 0, 50, 16'hDEAD, 16'hBEEF, 16'hCAFE); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200);
    check("ign_count", acc_addr.size(), 24);
    check("ign_last_addr", acc_addr[23], 3665);
    check("ign_last_data", acc_data[23], 32'h0F0F);

    // Reset in the middle of LEFT, then redraw
    launch(10, 12, 20, 22, 16'h00FF, 16'h0000, 16'h0F0F);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_wren", wren, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", acc_addr.size(), 19);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    draw(10, 12, 20, 22, 16'h00FF, 16'h0000, 16'h0F0F);
    check("redraw_count", acc_addr.size(), 24);
    check("redraw_addr0", acc_addr[0], 3060);

    // Clamped right corner
    draw(97, 200, 5, 6, 16'h0001, 16'h0002, 16'h0003);
    check("clamp_count", acc_addr.size(), 18);
    check("clamp_top_last", acc_addr[6], 29715);
    check("clamp_top_last_b", acc_addr[8], 29717);

    // Random boxes with random stalls
    wr_mode = 1;
    for (int k = 0; k < 15; k++) begin
      int a0, a1, b0, b1;
      a0 = $urandom_range(0, 110); a1 = $urandom_range(0, 110);
      b0 = $urandom_range(0, 110); b1 = $urandom_range(0, 110);
      if ($urandom_range(0, 3) != 0) begin
        if (a0 > a1) begin int t; t = a0; a0 = a1; a1 = t; end
        if (b0 > b1) begin int t; t = b0; b0 = b1; b1 = t; end
      end
      draw(a0, a1, b0, b1, 16'($urandom), 16'($urandom), 16'($urandom));
    end
    wr_mode = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
